// File: rtl/control_sequencer_pkg.sv
// Shared types and codes for the multi-cycle control sequencer.
//   opcode_e : 4-bit opcode field values
//   state_e  : sequencer FSM states (HALT only with CONTROL_SEQUENCER_HALT_EN)
//   F_*      : ALU function select codes driven on f_CU
//   B_*      : ALU B-operand mux codes driven on B_sel_CU
//   ctl_t    : decoded control bundle produced by control_sequencer_decode
// Optional feature macro: CONTROL_SEQUENCER_HALT_EN (adds HALT state / halt bit).
package control_sequencer_pkg;

   typedef enum logic [3:0] {
      OPC_NOP  = 4'h0,
      OPC_LDI  = 4'h4,
      OPC_IO   = 4'h5,
      OPC_MOV  = 4'h6,
      OPC_INCA = 4'h8,
      OPC_INCB = 4'h9,
      OPC_ADD  = 4'hA,
      OPC_SUB  = 4'hB,
      OPC_AND  = 4'hC,
      OPC_OR   = 4'hD,
      OPC_JZ   = 4'hE,
      OPC_JMP  = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE
`ifdef CONTROL_SEQUENCER_HALT_EN
      ,S_HALT
`endif
   } state_e;

   localparam logic [2:0] F_PASS = 3'b000;
   localparam logic [2:0] F_MOVB = 3'b001;
   localparam logic [2:0] F_INCA = 3'b010;
   localparam logic [2:0] F_INCB = 3'b011;
   localparam logic [2:0] F_ADD  = 3'b100;
   localparam logic [2:0] F_SUB  = 3'b101;
   localparam logic [2:0] F_AND  = 3'b110;
   localparam logic [2:0] F_OR   = 3'b111;

   localparam logic [1:0] B_REGB = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_PORT = 2'b11;

   // Low-field sub-opcodes for the IO / MOV / NOP groups
   localparam int LOW_IN   = 0;
   localparam int LOW_OUT  = 1;
   localparam int LOW_MOVB = 0;
   localparam int LOW_HALT = 15;

   typedef struct packed {
      logic [2:0] f;
      logic [1:0] b_sel;
      logic       wr_a;
      logic       wr_b;
      logic       wr_o;
      logic       wr_cz;
      logic       wr_pc;
      logic       pc_sel;
      logic       illegal;
`ifdef CONTROL_SEQUENCER_HALT_EN
      logic       halt;
`endif
   } ctl_t;

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational instruction decoder: opcode + low field + zero flag -> ctl_t.
// Ports:
//   opc_i    : opcode field of the latched instruction
//   low_i    : immediate / sub-opcode field of the latched instruction
//   flag_z_i : registered ALU zero flag (used by JZ)
//   ctl_o    : control bundle, registered by the sequencer in DECODE
// Optional feature macro: CONTROL_SEQUENCER_HALT_EN (0000_1111 decodes as HALT).
module control_sequencer_decode
   import control_sequencer_pkg::*;
#(
   parameter int OPC_W = 4,
   parameter int IMM_W = 4
) (
   input  logic [OPC_W-1:0] opc_i,
   input  logic [IMM_W-1:0] low_i,
   input  logic             flag_z_i,
   output ctl_t             ctl_o
);

   always_comb begin
      ctl_o       = '0;
      ctl_o.wr_pc = 1'b1;
      case (opc_i)
         OPC_NOP: begin
`ifdef CONTROL_SEQUENCER_HALT_EN
            // HALT issues no strobes at all, not even the PC write
            if (low_i == IMM_W'(LOW_HALT)) begin
               ctl_o.wr_pc = 1'b0;
               ctl_o.halt  = 1'b1;
            end
`endif
         end
         OPC_LDI: begin
            ctl_o.b_sel = B_IMM;
            ctl_o.wr_a  = 1'b1;
            ctl_o.wr_cz = 1'b1;
         end
         OPC_IO: begin
            if (low_i == IMM_W'(LOW_IN)) begin
               ctl_o.b_sel = B_PORT;
               ctl_o.wr_a  = 1'b1;
               ctl_o.wr_cz = 1'b1;
            end else if (low_i == IMM_W'(LOW_OUT)) begin
               ctl_o.wr_o  = 1'b1;
               ctl_o.wr_cz = 1'b1;
            end else begin
               ctl_o.illegal = 1'b1;
            end
         end
         OPC_MOV: begin
            if (low_i == IMM_W'(LOW_MOVB)) begin
               ctl_o.f     = F_MOVB;
               ctl_o.wr_b  = 1'b1;
               ctl_o.wr_cz = 1'b1;
            end else begin
               ctl_o.illegal = 1'b1;
            end
         end
         OPC_INCA: begin
            ctl_o.f     = F_INCA;
            ctl_o.wr_a  = 1'b1;
            ctl_o.wr_cz = 1'b1;
         end
         OPC_INCB: begin
            ctl_o.f     = F_INCB;
            ctl_o.b_sel = B_REGB;
            ctl_o.wr_b  = 1'b1;
            ctl_o.wr_cz = 1'b1;
         end
         OPC_ADD: begin
            ctl_o.f     = F_ADD;
            ctl_o.wr_a  = 1'b1;
            ctl_o.wr_cz = 1'b1;
         end
         OPC_SUB: begin
            ctl_o.f     = F_SUB;
            ctl_o.wr_a  = 1'b1;
            ctl_o.wr_cz = 1'b1;
         end
         OPC_AND: begin
            ctl_o.f     = F_AND;
            ctl_o.wr_a  = 1'b1;
            ctl_o.wr_cz = 1'b1;
         end
         OPC_OR: begin
            ctl_o.f     = F_OR;
            ctl_o.wr_a  = 1'b1;
            ctl_o.wr_cz = 1'b1;
         end
         OPC_JZ: begin
            ctl_o.pc_sel = flag_z_i;
         end
         OPC_JMP: begin
            ctl_o.pc_sel = 1'b1;
         end
         default: begin
            // undefined opcodes still advance the PC so the program keeps running
            ctl_o.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU.
// FETCH -> DECODE -> EXECUTE -> FETCH; all outputs registered.
// Ports:
//   in_clk, in_reset          : clock, synchronous active-high reset
//   instr_valid, instr_data   : program-memory response
//   flag_c, flag_z            : registered ALU flags (only Z is consumed, by JZ)
//   fetch_req                 : high throughout FETCH
//   f_CU, B_sel_CU, imm_CU    : ALU function, B-mux select, latched immediate
//   write_*_CU, write_pc_CU   : one-cycle strobes in EXECUTE
//   PC_sel_CU                 : 0 = PC+1, 1 = PC <= imm_CU
//   illegal_op                : one-cycle pulse in EXECUTE for undefined opcodes
//   halted                    : high in HALT (only with CONTROL_SEQUENCER_HALT_EN)
// Optional feature macro: CONTROL_SEQUENCER_HALT_EN.
//
// state   | meaning
// FETCH   | fetch_req high, wait for instr_valid, latch instruction
// DECODE  | register decoded controls (JZ samples flag_z here)
// EXECUTE | strobes high for this cycle only
// HALT    | parked until reset, fetch_req low (optional)
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OPC_W  = 4,
   localparam int IMM_W = DATA_W - OPC_W
) (
   input  logic              in_clk,
   input  logic              in_reset,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr_data,
   input  logic              flag_c,
   input  logic              flag_z,
   output logic              fetch_req,
   output logic [2:0]        f_CU,
   output logic [1:0]        B_sel_CU,
   output logic [IMM_W-1:0]  imm_CU,
   output logic              write_a_CU,
   output logic              write_b_CU,
   output logic              write_o_CU,
   output logic              write_cz_CU,
   output logic              PC_sel_CU,
   output logic              write_pc_CU,
   output logic              illegal_op
`ifdef CONTROL_SEQUENCER_HALT_EN
   ,output logic             halted
`endif
);

   state_e            state_q;
   logic [DATA_W-1:0] instr_q;
   logic              fetch_req_q;
   logic [2:0]        f_q;
   logic [1:0]        b_sel_q;
   logic [IMM_W-1:0]  imm_q;
   logic              wr_a_q, wr_b_q, wr_o_q, wr_cz_q, wr_pc_q;
   logic              pc_sel_q, illegal_q;
   ctl_t              ctl_d;
`ifdef CONTROL_SEQUENCER_HALT_EN
   logic              halt_q;
   logic              halted_q;
`endif

   // Carry is part of the datapath interface but no current opcode branches on it
   logic unused_flag_c;
   assign unused_flag_c = flag_c;

   control_sequencer_decode #(
      .OPC_W (OPC_W),
      .IMM_W (IMM_W)
   ) u_decode (
      .opc_i    (instr_q[DATA_W-1 -: OPC_W]),
      .low_i    (instr_q[IMM_W-1:0]),
      .flag_z_i (flag_z),
      .ctl_o    (ctl_d)
   );

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state_q     <= S_FETCH;
         instr_q     <= '0;
         fetch_req_q <= 1'b0;
         f_q         <= F_PASS;
         b_sel_q     <= B_REGB;
         imm_q       <= '0;
         wr_a_q      <= 1'b0;
         wr_b_q      <= 1'b0;
         wr_o_q      <= 1'b0;
         wr_cz_q     <= 1'b0;
         wr_pc_q     <= 1'b0;
         pc_sel_q    <= 1'b0;
         illegal_q   <= 1'b0;
`ifdef CONTROL_SEQUENCER_HALT_EN
         halt_q      <= 1'b0;
         halted_q    <= 1'b0;
`endif
      end else begin
         // strobes drop after every cycle; only DECODE re-arms them
         wr_a_q    <= 1'b0;
         wr_b_q    <= 1'b0;
         wr_o_q    <= 1'b0;
         wr_cz_q   <= 1'b0;
         wr_pc_q   <= 1'b0;
         illegal_q <= 1'b0;
         unique case (state_q)
            S_FETCH: begin
               // first cycle after reset only raises fetch_req; the request
               // must be visible before a response is accepted
               fetch_req_q <= 1'b1;
               if (fetch_req_q && instr_valid) begin
                  instr_q     <= instr_data;
                  fetch_req_q <= 1'b0;
                  state_q     <= S_DECODE;
               end
            end
            S_DECODE: begin
               f_q       <= ctl_d.f;
               b_sel_q   <= ctl_d.b_sel;
               imm_q     <= instr_q[IMM_W-1:0];
               wr_a_q    <= ctl_d.wr_a;
               wr_b_q    <= ctl_d.wr_b;
               wr_o_q    <= ctl_d.wr_o;
               wr_cz_q   <= ctl_d.wr_cz;
               wr_pc_q   <= ctl_d.wr_pc;
               pc_sel_q  <= ctl_d.pc_sel;
               illegal_q <= ctl_d.illegal;
`ifdef CONTROL_SEQUENCER_HALT_EN
               halt_q    <= ctl_d.halt;
`endif
               state_q   <= S_EXECUTE;
            end
            S_EXECUTE: begin
`ifdef CONTROL_SEQUENCER_HALT_EN
               if (halt_q) begin
                  halted_q <= 1'b1;
                  state_q  <= S_HALT;
               end else begin
                  fetch_req_q <= 1'b1;
                  state_q     <= S_FETCH;
               end
`else
               // raise fetch_req together with the FETCH entry so a waiting
               // memory response is taken in the very first FETCH cycle
               fetch_req_q <= 1'b1;
               state_q     <= S_FETCH;
`endif
            end
`ifdef CONTROL_SEQUENCER_HALT_EN
            S_HALT: begin
               state_q <= S_HALT;
            end
`endif
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   assign fetch_req   = fetch_req_q;
   assign f_CU        = f_q;
   assign B_sel_CU    = b_sel_q;
   assign imm_CU      = imm_q;
   assign write_a_CU  = wr_a_q;
   assign write_b_CU  = wr_b_q;
   assign write_o_CU  = wr_o_q;
   assign write_cz_CU = wr_cz_q;
   assign write_pc_CU = wr_pc_q;
   assign PC_sel_CU   = pc_sel_q;
   assign illegal_op  = illegal_q;
`ifdef CONTROL_SEQUENCER_HALT_EN
   assign halted      = halted_q;
`endif

endmodule
